// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-entry valid/busy scoreboard bits.
// Define REGFILE_MP_ZERO_REG_EN to hardwire address 0 to zero.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int RPORTS = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [RPORTS*AW-1:0]     tick_raddr,
  input  logic [AW-1:0]            tick_waddr,
  input  logic [WIDTH-1:0]         tick_wdata,
  input  logic                     tick_wren,
  input  logic [AW-1:0]            tick_rsv_addr,
  input  logic                     tick_rsv_en,
  output logic [RPORTS*WIDTH-1:0]  get_rdata_ret,
  output logic [RPORTS-1:0]        get_rbusy_ret,
  output logic                     get_busy_any_ret
);

`ifdef REGFILE_MP_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [DEPTH-1:0] ANY_MASK =
    ~{{(DEPTH-1){1'b0}}, ZERO_REG};

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [RPORTS*WIDTH-1:0] rdata_q, rdata_d;
  logic [RPORTS-1:0]       rbusy_q, rbusy_d;
  logic                    any_q, any_d;
  logic                    wr_en, rsv_en;

  assign wr_en  = tick_wren &
                  ~(ZERO_REG & (tick_waddr == '0));
  assign rsv_en = tick_rsv_en &
                  ~(ZERO_REG & (tick_rsv_addr == '0));

  // Reserve is applied after write so it wins on a shared address.
  always_comb begin
    valid_d = valid_q;
    busy_d  = busy_q;
    if (wr_en) begin
      valid_d[tick_waddr] = 1'b1;
      busy_d[tick_waddr]  = 1'b0;
    end
    if (rsv_en) begin
      busy_d[tick_rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rdata_d = '0;
    rbusy_d = '0;
    for (int p = 0; p < RPORTS; p++) begin
      ra = tick_raddr[p*AW +: AW];
      if (wr_en && (ra == tick_waddr)) begin
        rdata_d[p*WIDTH +: WIDTH] = tick_wdata;
      end else if (valid_q[ra]) begin
        rdata_d[p*WIDTH +: WIDTH] = mem_q[ra];
      end else begin
        rdata_d[p*WIDTH +: WIDTH] = '0;
      end
      rbusy_d[p] = busy_d[ra];
    end
    any_d = |(busy_d & ANY_MASK);
  end

  // Storage is never reset; valid_q hides stale contents.
  always_ff @(posedge clock) begin
    if (wr_en && reset_n) begin
      mem_q[tick_waddr] <= tick_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      busy_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
      any_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
      any_q   <= any_d;
    end
  end

  assign get_rdata_ret    = rdata_q;
  assign get_rbusy_ret    = rbusy_q;
  assign get_busy_any_ret = any_q;

endmodule
